// File: rtl/window_addr_gen_if.sv
// ---------------------------------------------------------------------------
// window_addr_gen_if
// Purpose : control and tap-stream bundle between the controller / image
//           memory side and the window address generator.
// Signals : start, mode            run request and padding mode (to generator)
//           busy, done             run status (from generator)
//           out_valid, out_ready   tap handshake
//           addr, zero_pad         tap payload: frame-buffer address, zero flag
//           tap_last, win_last     end-of-window / last-window markers
// Modports: master = generator side, slave = controller / consumer side.
// ---------------------------------------------------------------------------
interface window_addr_gen_if #(
    parameter int unsigned ADDR_W = 12
);
    logic              start;
    logic              mode;
    logic              busy;
    logic              done;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] addr;
    logic              zero_pad;
    logic              tap_last;
    logic              win_last;

    modport master (
        input  start, mode, out_ready,
        output busy, done, out_valid, addr, zero_pad, tap_last, win_last
    );

    modport slave (
        output start, mode, out_ready,
        input  busy, done, out_valid, addr, zero_pad, tap_last, win_last
    );
endinterface

// File: rtl/window_addr_gen.sv
// ---------------------------------------------------------------------------
// window_addr_gen
// Purpose : walks every centre of an IMG_H x IMG_W image in raster order and,
//           for each, streams the K x K neighbourhood as frame-buffer addresses.
//           Border taps are clamped to the image (replicate) or, in zero mode,
//           flagged with zero_pad while still carrying the clamped address.
// Ports   : clk    rising-edge clock
//           reset  asynchronous, active-high reset (aborts a run, no done)
//           bus    window_addr_gen_if.master: start/mode in, tap stream with
//                  out_valid/out_ready handshake out, busy/done status out.
//           All outputs are registered.
// ---------------------------------------------------------------------------
module window_addr_gen #(
    parameter int unsigned IMG_W  = 64,
    parameter int unsigned IMG_H  = 64,
    parameter int unsigned K      = 5,
    parameter int unsigned PAD    = 2,
    parameter int unsigned ADDR_W = $clog2(IMG_W * IMG_H)
) (
    input  logic                   clk,
    input  logic                   reset,
    window_addr_gen_if.master      bus
);

    localparam int unsigned MAX_DIM = (IMG_W > IMG_H) ? IMG_W : IMG_H;
    // Signed virtual coordinate width: covers -PAD .. MAX_DIM-1+PAD untruncated.
    localparam int unsigned VW = $clog2(MAX_DIM + 2 * PAD) + 1;
    localparam int unsigned RW = $clog2(IMG_H);
    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned TW = (K > 1) ? $clog2(K) : 1;

    localparam logic [TW-1:0]        T_MAX   = TW'(K - 1);
    localparam logic [RW-1:0]        CR_MAX  = RW'(IMG_H - 1);
    localparam logic [CW-1:0]        CC_MAX  = CW'(IMG_W - 1);
    localparam logic signed [VW-1:0] ROW_MAX = VW'(IMG_H - 1);
    localparam logic signed [VW-1:0] COL_MAX = VW'(IMG_W - 1);

    if (K != 2 * PAD + 1) begin : g_bad_cfg
        $error("window_addr_gen: K must equal 2*PAD+1");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [RW-1:0] cr_q, cr_d;
    logic [CW-1:0] cc_q, cc_d;
    logic [TW-1:0] dy_q, dy_d;
    logic [TW-1:0] dx_q, dx_d;
    logic          mode_q, mode_d;

    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              zp_q, zp_d;
    logic              tl_q, tl_d;
    logic              wl_q, wl_d;

    logic                 hs;
    logic signed [VW-1:0] vr, vc;
    logic                 row_lo, row_hi, col_lo, col_hi;
    logic [RW-1:0]        pr;
    logic [CW-1:0]        pc;

    assign hs = valid_q & bus.out_ready;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and tap/centre counters
    always_comb begin
        state_d = state_q;
        cr_d    = cr_q;
        cc_d    = cc_q;
        dy_d    = dy_q;
        dx_d    = dx_q;
        mode_d  = mode_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_RUN;
                    mode_d  = bus.mode;
                    cr_d    = '0;
                    cc_d    = '0;
                    dy_d    = '0;
                    dx_d    = '0;
                end
            end
            S_RUN: begin
                if (hs) begin
                    // The registered markers already identify the final tap.
                    if (tl_q && wl_q) begin
                        state_d = S_DONE;
                        cr_d    = '0;
                        cc_d    = '0;
                        dy_d    = '0;
                        dx_d    = '0;
                    end else if (dx_q != T_MAX) begin
                        dx_d = dx_q + TW'(1);
                    end else begin
                        dx_d = '0;
                        if (dy_q != T_MAX) begin
                            dy_d = dy_q + TW'(1);
                        end else begin
                            dy_d = '0;
                            if (cc_q != CC_MAX) begin
                                cc_d = cc_q + CW'(1);
                            end else begin
                                cc_d = '0;
                                cr_d = cr_q + RW'(1);
                            end
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output values for the next cycle, derived from the next-state counters
    always_comb begin
        busy_d  = 1'b0;
        done_d  = 1'b0;
        valid_d = 1'b0;
        addr_d  = '0;
        zp_d    = 1'b0;
        tl_d    = 1'b0;
        wl_d    = 1'b0;

        vr = $signed(VW'(cr_d)) + $signed(VW'(dy_d)) - $signed(VW'(PAD));
        vc = $signed(VW'(cc_d)) + $signed(VW'(dx_d)) - $signed(VW'(PAD));

        row_lo = vr[VW-1];
        row_hi = !vr[VW-1] && (vr > ROW_MAX);
        col_lo = vc[VW-1];
        col_hi = !vc[VW-1] && (vc > COL_MAX);

        pr = row_lo ? '0 : (row_hi ? CR_MAX : vr[RW-1:0]);
        pc = col_lo ? '0 : (col_hi ? CC_MAX : vc[CW-1:0]);

        if (state_d == S_RUN) begin
            busy_d  = 1'b1;
            valid_d = 1'b1;
            addr_d  = ADDR_W'(pr) * ADDR_W'(IMG_W) + ADDR_W'(pc);
            zp_d    = mode_d & (row_lo | row_hi | col_lo | col_hi);
            tl_d    = (dy_d == T_MAX) && (dx_d == T_MAX);
            wl_d    = (cr_d == CR_MAX) && (cc_d == CC_MAX);
        end
        done_d = (state_d == S_DONE);
    end

    // Counter, mode and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cr_q    <= '0;
            cc_q    <= '0;
            dy_q    <= '0;
            dx_q    <= '0;
            mode_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            addr_q  <= '0;
            zp_q    <= 1'b0;
            tl_q    <= 1'b0;
            wl_q    <= 1'b0;
        end else begin
            cr_q    <= cr_d;
            cc_q    <= cc_d;
            dy_q    <= dy_d;
            dx_q    <= dx_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            zp_q    <= zp_d;
            tl_q    <= tl_d;
            wl_q    <= wl_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.out_valid = valid_q;
    assign bus.addr      = addr_q;
    assign bus.zero_pad  = zp_q;
    assign bus.tap_last  = tl_q;
    assign bus.win_last  = wl_q;

endmodule

// File: tb/tb_window_addr_gen.sv
// ---------------------------------------------------------------------------
// tb_window_addr_gen
// Purpose : directed bench for window_addr_gen. Three instances: default
//           64x64 K5 (start-up, padding modes, abort), 12x10 K5 (complete runs,
//           with and without backpressure) and 8x8 K3 (small-geometry run).
// ---------------------------------------------------------------------------
module tb_window_addr_gen;

    logic clk;
    logic reset;
    int   sel;
    logic start, mode, out_ready;

    logic        obs_busy, obs_done, obs_valid, obs_zp, obs_tl, obs_wl;
    logic [31:0] obs_addr;

    int checks = 0;
    int errors = 0;

    logic [34:0] acc[$];
    int          n_beats;

    window_addr_gen_if #(.ADDR_W(12)) big_if ();
    window_addr_gen_if #(.ADDR_W(7))  mid_if ();
    window_addr_gen_if #(.ADDR_W(6))  small_if ();

    window_addr_gen #(.IMG_W(64), .IMG_H(64), .K(5), .PAD(2), .ADDR_W(12)) u_big (
        .clk   (clk),
        .reset (reset),
        .bus   (big_if.master)
    );

    window_addr_gen #(.IMG_W(12), .IMG_H(10), .K(5), .PAD(2), .ADDR_W(7)) u_mid (
        .clk   (clk),
        .reset (reset),
        .bus   (mid_if.master)
    );

    window_addr_gen #(.IMG_W(8), .IMG_H(8), .K(3), .PAD(1), .ADDR_W(6)) u_small (
        .clk   (clk),
        .reset (reset),
        .bus   (small_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign big_if.start     = (sel == 0) ? start : 1'b0;
    assign big_if.mode      = (sel == 0) ? mode : 1'b0;
    assign big_if.out_ready = (sel == 0) ? out_ready : 1'b0;
    assign mid_if.start     = (sel == 1) ? start : 1'b0;
    assign mid_if.mode      = (sel == 1) ? mode : 1'b0;
    assign mid_if.out_ready = (sel == 1) ? out_ready : 1'b0;
    assign small_if.start     = (sel == 2) ? start : 1'b0;
    assign small_if.mode      = (sel == 2) ? mode : 1'b0;
    assign small_if.out_ready = (sel == 2) ? out_ready : 1'b0;

    // Observation mux onto the instance under test
    always_comb begin
        case (sel)
            1: begin
                obs_busy = mid_if.busy;  obs_done = mid_if.done;  obs_valid = mid_if.out_valid;
                obs_zp   = mid_if.zero_pad; obs_tl = mid_if.tap_last; obs_wl = mid_if.win_last;
                obs_addr = 32'(mid_if.addr);
            end
            2: begin
                obs_busy = small_if.busy;  obs_done = small_if.done;  obs_valid = small_if.out_valid;
                obs_zp   = small_if.zero_pad; obs_tl = small_if.tap_last; obs_wl = small_if.win_last;
                obs_addr = 32'(small_if.addr);
            end
            default: begin
                obs_busy = big_if.busy;  obs_done = big_if.done;  obs_valid = big_if.out_valid;
                obs_zp   = big_if.zero_pad; obs_tl = big_if.tap_last; obs_wl = big_if.win_last;
                obs_addr = 32'(big_if.addr);
            end
        endcase
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Reference tap: {tap_last, win_last, zero_pad, addr[31:0]} for a beat index
    function automatic logic [34:0] model(input int w, input int h, input int k, input int p,
                                          input bit md, input int beat);
        int kk, tap, win, cr, cc, vr, vc, pr, pc;
        bit outside;
        kk  = k * k;
        tap = beat % kk;
        win = beat / kk;
        cr  = win / w;
        cc  = win % w;
        vr  = cr + tap / k - p;
        vc  = cc + tap % k - p;
        outside = (vr < 0) || (vr >= h) || (vc < 0) || (vc >= w);
        pr = (vr < 0) ? 0 : ((vr >= h) ? h - 1 : vr);
        pc = (vc < 0) ? 0 : ((vc >= w) ? w - 1 : vc);
        return {tap == kk - 1, win == w * h - 1, md && outside, 32'(pr * w + pc)};
    endfunction

    function automatic logic [34:0] beat_at(input int i);
        if (i < acc.size()) return acc[i];
        return '1;
    endfunction

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Start a run on the selected instance and score every accepted tap.
    // abort_at >= 0 returns mid-run (DUT still busy) after that many beats.
    task automatic run_stream(input int w, input int h, input int k, input int p,
                              input bit md, input bit rnd, input int glitch, input int abort_at);
        int total, limit, budget, n, cyc, dcnt;
        bit stall;
        logic [34:0] cur, held;
        total  = w * h * k * k;
        limit  = (abort_at >= 0) ? abort_at : total;
        budget = limit * 6 + 50;
        acc.delete();
        n = 0; cyc = 0; dcnt = 0; stall = 1'b0; held = '0;
        mode = md; out_ready = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("valid_rise", obs_valid, 1);
        check("busy_rise", obs_busy, 1);
        while (n < limit && cyc < budget) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start     = (glitch >= 0) && (n == glitch);
            cur = {obs_tl, obs_wl, obs_zp, obs_addr};
            if (stall) check("stall_hold", {obs_valid, cur}, {1'b1, held});
            dcnt += int'(obs_done);
            if (obs_valid && out_ready) begin
                check($sformatf("beat%0d", n), cur, model(w, h, k, p, md, n));
                acc.push_back(cur);
                n++;
            end
            stall = obs_valid && !out_ready;
            held  = cur;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("early_done", dcnt, 0);
        if (n < limit) check("beat_timeout", n, limit);
        if (abort_at < 0) begin
            check("done_pulse", obs_done, 1);
            check("valid_off", obs_valid, 0);
            @(negedge clk);
            check("done_once", obs_done, 0);
            check("busy_off", obs_busy, 0);
        end
        n_beats = n;
    endtask

    initial begin
        logic [34:0] v;
        int dseen;
        sel = 0; start = 1'b0; mode = 1'b0; out_ready = 1'b0; reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_outputs", {obs_busy, obs_done, obs_valid, obs_zp, obs_tl, obs_wl, obs_addr}, 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_outputs", {obs_busy, obs_done, obs_valid, obs_addr}, 0);

        // 64x64, replicate padding: first window
        run_stream(64, 64, 5, 2, 1'b0, 1'b0, -1, 30);
        v = beat_at(0);  check("s1_b0_addr", v[31:0], 0);  check("s1_b0_zp", v[32], 0);
        v = beat_at(12); check("s1_b12_addr", v[31:0], 0);
        v = beat_at(24); check("s1_b24_addr", v[31:0], 130); check("s1_b24_tl", v[34], 1);
        pulse_reset();

        // 64x64, zero padding: first window
        run_stream(64, 64, 5, 2, 1'b1, 1'b0, -1, 30);
        v = beat_at(0);  check("s2_b0_zp", v[32], 1); check("s2_b0_addr", v[31:0], 0);
        v = beat_at(12); check("s2_b12_zp", v[32], 0);
        v = beat_at(24); check("s2_b24_zp", v[32], 0); check("s2_b24_addr", v[31:0], 130);
        pulse_reset();

        // 64x64, start pulsed while busy, then abort by reset at beat 5000
        run_stream(64, 64, 5, 2, 1'b0, 1'b0, 100, 5000);
        reset = 1'b1;
        #1;
        check("abort_outputs", {obs_busy, obs_done, obs_valid, obs_zp, obs_tl, obs_wl, obs_addr}, 0);
        @(negedge clk);
        reset = 1'b0;
        dseen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            dseen += int'(obs_done) + int'(obs_busy);
        end
        check("abort_no_done", dseen, 0);
        run_stream(64, 64, 5, 2, 1'b0, 1'b0, -1, 1);
        v = beat_at(0); check("s5_restart_b0", v, 0);
        pulse_reset();

        // 12x10 full run without backpressure
        sel = 1;
        @(negedge clk);
        run_stream(12, 10, 5, 2, 1'b0, 1'b0, -1, -1);
        check("s3_count", n_beats, 3000);
        v = beat_at(2999);
        check("s3_last_addr", v[31:0], 119); check("s3_last_wl", v[33], 1); check("s3_last_tl", v[34], 1);

        // 12x10 full run with random backpressure
        run_stream(12, 10, 5, 2, 1'b0, 1'b1, -1, -1);
        check("s4_count", n_beats, 3000);

        // 8x8, K=3, zero padding
        sel = 2;
        @(negedge clk);
        run_stream(8, 8, 3, 1, 1'b1, 1'b0, -1, -1);
        check("s6_count", n_beats, 576);
        v = beat_at(261); check("s6_c35_addr", v[31:0], 20); check("s6_c35_zp", v[32], 0);
        v = beat_at(65);  check("s6_c07_addr", v[31:0], 7);  check("s6_c07_zp", v[32], 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
